// File: rtl/pc_sequencer.sv
// Registered program counter with sequential, jump, branch, call and return
// selection, backed by a circular return-address stack with sticky misuse flags.
module pc_sequencer #(
   parameter int ADDR_WIDTH = 10,
   parameter int INC        = 1,
   parameter int RAS_DEPTH  = 4,
   parameter int RESET_PC   = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           stall,
   input  logic                           jump,
   input  logic                           branch_taken,
   input  logic                           call,
   input  logic                           ret,
   input  logic [ADDR_WIDTH-1:0]          target,
   input  logic [ADDR_WIDTH-1:0]          branch_offset,
   output logic [ADDR_WIDTH-1:0]          pc,
   output logic [ADDR_WIDTH-1:0]          pc_plus_inc,
   output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
   output logic                           ras_overflow,
   output logic                           ras_underflow
);

   localparam int CNT_W = $clog2(RAS_DEPTH+1);
   localparam int PTR_W = $clog2(RAS_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] INC_A    = ADDR_WIDTH'(INC);
   localparam logic [ADDR_WIDTH-1:0] RESET_A  = ADDR_WIDTH'(RESET_PC);
   localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(RAS_DEPTH);
   localparam logic [PTR_W-1:0]      LAST_PTR = PTR_W'(RAS_DEPTH-1);

   function automatic logic [ADDR_WIDTH-1:0] wrap_add(
      input logic        [ADDR_WIDTH-1:0] base,
      input logic signed [ADDR_WIDTH-1:0] delta
   );
      return base + $unsigned(delta);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   function automatic logic [PTR_W-1:0] ptr_prev(input logic [PTR_W-1:0] p);
      return (p == '0) ? LAST_PTR : p - PTR_W'(1);
   endfunction

   logic [ADDR_WIDTH-1:0]        ras_mem [RAS_DEPTH];
   logic [PTR_W-1:0]             wr_ptr;
   logic [PTR_W-1:0]             top_ptr;
   logic [ADDR_WIDTH-1:0]        pc_nxt;
   logic signed [ADDR_WIDTH-1:0] offset_s;
   logic                         do_push;
   logic                         do_pop;
   logic                         set_ov;
   logic                         set_un;

   assign pc_plus_inc = pc + INC_A;
   assign offset_s    = branch_offset;
   // wr_ptr is the next free slot; the newest entry sits just below it
   assign top_ptr     = ptr_prev(wr_ptr);

   always_comb begin
      pc_nxt  = pc;
      do_push = 1'b0;
      do_pop  = 1'b0;
      set_ov  = 1'b0;
      set_un  = 1'b0;
      if (!stall) begin
         if (ret) begin
            if (ras_count != '0) begin
               pc_nxt = ras_mem[top_ptr];
               do_pop = 1'b1;
            end else begin
               pc_nxt = pc_plus_inc;
               set_un = 1'b1;
            end
         end else if (call) begin
            pc_nxt  = target;
            do_push = 1'b1;
            set_ov  = (ras_count == FULL_CNT);
         end else if (jump) begin
            pc_nxt = target;
         end else if (branch_taken) begin
            pc_nxt = wrap_add(pc, offset_s);
         end else begin
            pc_nxt = pc_plus_inc;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc            <= RESET_A;
         wr_ptr        <= '0;
         ras_count     <= '0;
         ras_overflow  <= 1'b0;
         ras_underflow <= 1'b0;
      end else begin
         pc <= pc_nxt;
         // a push onto a full stack overwrites the oldest slot, so the count saturates
         if (do_push) begin
            wr_ptr <= ptr_next(wr_ptr);
            if (ras_count != FULL_CNT) begin
               ras_count <= ras_count + CNT_W'(1);
            end
         end else if (do_pop) begin
            wr_ptr    <= top_ptr;
            ras_count <= ras_count - CNT_W'(1);
         end
         if (set_ov) begin
            ras_overflow <= 1'b1;
         end
         if (set_un) begin
            ras_underflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         ras_mem[wr_ptr] <= pc_plus_inc;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, reset corner sequences and
// randomized control traffic checked against a queue-based reference model.
module tb_pc_sequencer;

   localparam int MASK  = 1023;
   localparam int DEPTH = 4;
   localparam int S = 16, R = 8, C = 4, J = 2, B = 1;

   logic       clk;
   logic       rst_n;
   logic       stall, jump, branch_taken, call, ret;
   logic [9:0] target, branch_offset;
   logic [9:0] pc, pc_plus_inc;
   logic [2:0] ras_count;
   logic       ras_overflow, ras_underflow;

   int total = 0;
   int bad   = 0;

   int m_pc;
   int m_q[$];
   int m_ov;
   int m_un;

   typedef struct {
      int ctl;
      int t;
      int o;
      int epc;
      int ecnt;
      int eov;
      int eun;
   } vec_t;

   vec_t vecs[$];

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .jump(jump),
      .branch_taken(branch_taken), .call(call), .ret(ret),
      .target(target), .branch_offset(branch_offset),
      .pc(pc), .pc_plus_inc(pc_plus_inc), .ras_count(ras_count),
      .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic vec_t v(int ctl, int t, int o, int epc, int ecnt, int eov, int eun);
      vec_t r;
      r.ctl = ctl; r.t = t; r.o = o; r.epc = epc;
      r.ecnt = ecnt; r.eov = eov; r.eun = eun;
      return r;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int ctl, input int t, input int o);
      stall        = (ctl & S) != 0;
      ret          = (ctl & R) != 0;
      call         = (ctl & C) != 0;
      jump         = (ctl & J) != 0;
      branch_taken = (ctl & B) != 0;
      target        = t[9:0];
      branch_offset = o[9:0];
   endtask

   task automatic apply(input int ctl, input int t, input int o);
      drive(ctl, t, o);
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      m_pc = 0;
      m_q.delete();
      m_ov = 0;
      m_un = 0;
   endtask

   task automatic model_step(input int ctl, input int t, input int o);
      int off;
      if ((ctl & S) != 0) return;
      if ((ctl & R) != 0) begin
         if (m_q.size() > 0) m_pc = m_q.pop_back();
         else begin
            m_pc = (m_pc + 1) & MASK;
            m_un = 1;
         end
      end else if ((ctl & C) != 0) begin
         if (m_q.size() == DEPTH) begin
            void'(m_q.pop_front());
            m_ov = 1;
         end
         m_q.push_back((m_pc + 1) & MASK);
         m_pc = t & MASK;
      end else if ((ctl & J) != 0) begin
         m_pc = t & MASK;
      end else if ((ctl & B) != 0) begin
         off  = (o >= 512) ? o - 1024 : o;
         m_pc = (m_pc + off) & MASK;
      end else begin
         m_pc = (m_pc + 1) & MASK;
      end
   endtask

   initial begin
      // idle / wrap / branch
      for (int k = 1; k <= 5; k++) vecs.push_back(v(0, 0, 0, k, 0, 0, 0));
      vecs.push_back(v(J, 'h3FE, 0, 'h3FE, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 'h3FF, 0, 0, 0));
      vecs.push_back(v(0, 0, 0, 'h000, 0, 0, 0));
      vecs.push_back(v(J, 'h010, 0, 'h010, 0, 0, 0));
      vecs.push_back(v(B, 0, 'h3FC, 'h00C, 0, 0, 0));
      vecs.push_back(v(J, 'h005, 0, 'h005, 0, 0, 0));
      vecs.push_back(v(B, 0, 'h3F0, 'h3F5, 0, 0, 0));
      // priority and stall
      vecs.push_back(v(J, 'h100, 0, 'h100, 0, 0, 0));
      vecs.push_back(v(S|J, 'h200, 0, 'h100, 0, 0, 0));
      vecs.push_back(v(J|B, 'h200, 8, 'h200, 0, 0, 0));
      // nested call / ret
      vecs.push_back(v(J, 'h010, 0, 'h010, 0, 0, 0));
      vecs.push_back(v(C, 'h100, 0, 'h100, 1, 0, 0));
      vecs.push_back(v(C, 'h200, 0, 'h200, 2, 0, 0));
      vecs.push_back(v(S|R, 0, 0, 'h200, 2, 0, 0));
      vecs.push_back(v(R, 0, 0, 'h101, 1, 0, 0));
      vecs.push_back(v(R, 0, 0, 'h011, 0, 0, 0));
      // call+ret together performs the ret only
      vecs.push_back(v(J, 'h04F, 0, 'h04F, 0, 0, 0));
      vecs.push_back(v(C, 'h300, 0, 'h300, 1, 0, 0));
      vecs.push_back(v(S|C, 'h3AA, 0, 'h300, 1, 0, 0));
      vecs.push_back(v(C|R, 'h123, 0, 'h050, 0, 0, 0));
      // overflow then drain in LIFO order
      vecs.push_back(v(J, 'h010, 0, 'h010, 0, 0, 0));
      vecs.push_back(v(C, 'h020, 0, 'h020, 1, 0, 0));
      vecs.push_back(v(C, 'h030, 0, 'h030, 2, 0, 0));
      vecs.push_back(v(C, 'h040, 0, 'h040, 3, 0, 0));
      vecs.push_back(v(C, 'h050, 0, 'h050, 4, 0, 0));
      vecs.push_back(v(C, 'h060, 0, 'h060, 4, 1, 0));
      vecs.push_back(v(R, 0, 0, 'h051, 3, 1, 0));
      vecs.push_back(v(R, 0, 0, 'h041, 2, 1, 0));
      vecs.push_back(v(R, 0, 0, 'h031, 1, 1, 0));
      vecs.push_back(v(R, 0, 0, 'h021, 0, 1, 0));
      // underflow
      vecs.push_back(v(J, 'h030, 0, 'h030, 0, 1, 0));
      vecs.push_back(v(R, 0, 0, 'h031, 0, 1, 1));

      rst_n = 1'b0;
      drive(0, 0, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pc", int'(pc), 0);
      chk("rst_ppi", int'(pc_plus_inc), 1);
      chk("rst_cnt", int'(ras_count), 0);
      chk("rst_ov", int'(ras_overflow), 0);
      chk("rst_un", int'(ras_underflow), 0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i].ctl, vecs[i].t, vecs[i].o);
         chk($sformatf("vec%0d_pc", i), int'(pc), vecs[i].epc);
         chk($sformatf("vec%0d_ppi", i), int'(pc_plus_inc), (vecs[i].epc + 1) & MASK);
         chk($sformatf("vec%0d_cnt", i), int'(ras_count), vecs[i].ecnt);
         chk($sformatf("vec%0d_ov", i), int'(ras_overflow), vecs[i].eov);
         chk($sformatf("vec%0d_un", i), int'(ras_underflow), vecs[i].eun);
      end

      // asynchronous reset mid-cycle, with a call pending
      drive(C, 'h2AA, 0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_pc", int'(pc), 0);
      chk("async_cnt", int'(ras_count), 0);
      chk("async_ov", int'(ras_overflow), 0);
      chk("async_un", int'(ras_underflow), 0);
      @(posedge clk);
      #1;
      chk("held_rst_pc", int'(pc), 0);
      chk("held_rst_cnt", int'(ras_count), 0);
      rst_n = 1'b1;
      apply(0, 0, 0);
      chk("post_rst_pc", int'(pc), 1);
      chk("post_rst_cnt", int'(ras_count), 0);

      // randomized traffic against the reference model
      rst_n = 1'b0;
      #2;
      rst_n = 1'b1;
      model_reset();
      for (int n = 0; n < 2000; n++) begin
         int ctl, t, o;
         ctl = 0;
         if ($urandom_range(7) == 0) ctl |= S;
         if ($urandom_range(3) == 0) ctl |= R;
         if ($urandom_range(2) == 0) ctl |= C;
         if ($urandom_range(4) == 0) ctl |= J;
         if ($urandom_range(3) == 0) ctl |= B;
         t = ($urandom_range(5) == 0) ? 1020 + int'($urandom_range(3)) : int'($urandom_range(MASK));
         o = int'($urandom_range(MASK));
         model_step(ctl, t, o);
         apply(ctl, t, o);
         chk("rnd_pc", int'(pc), m_pc);
         chk("rnd_ppi", int'(pc_plus_inc), (m_pc + 1) & MASK);
         chk("rnd_cnt", int'(ras_count), m_q.size());
         chk("rnd_ov", int'(ras_overflow), m_ov);
         chk("rnd_un", int'(ras_underflow), m_un);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
